mpu_sequencer: RTL and testbench
================================

Name: mpu_sequencer

Overview:
Control FSM that drives the MPU execution stage.
- Owns the 16-bit instruction pointer and requests instruction fetches.
- Opens a one-cycle execute window per instruction and gates register-file writes through exec_commit.
- Stalls on host-memory loads and on user interrupts until the host responds.
- Sits between the CSR/host interface, the instruction memory/decoder and the combinational execution stage.

Parameters:
- IP_RESET, 16'h0000: IP value loaded on sys_rst and on ip_clear.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active-high
- en  in  1  run enable from CSR (level)
- ip_clear  in  1  reload IP with IP_RESET; honoured only in IDLE or HALT
- ip  out  16  current instruction pointer
- fetch_req  out  1  instruction fetch request at address ip
- fetch_ack  in  1  instruction word latched into decoder this cycle
- exec_commit  out  1  write-enable gate, ANDed with execution-stage we
- ip_incr  in  16  instruction size from execution stage
- ip_load  in  1  taken-jump indication from execution stage
- ip_data  in  16  jump target from execution stage
- hm_start  in  1  decoded instruction is a host memory load
- hm_req  out  1  one-cycle pulse: host read request
- hm_ack  in  1  host read data valid
- user_irq  in  1  decoded instruction is INT
- irq  out  1  interrupt pending to host (level)
- irq_clear  in  1  host acknowledges interrupt
- running  out  1  FSM not in IDLE or HALT
- error  out  1  sticky: zero-size instruction detected
- instr_count  out  32  committed-instruction counter

Behaviour:
- States: IDLE, FETCH, EXEC, HM_WAIT, IRQ_WAIT, HALT.
- Reset values (sys_rst, synchronous, wins over every other input):
  - state=IDLE, ip=IP_RESET.
  - fetch_req, exec_commit, hm_req, irq, running and error are all 0.
  - instr_count=0.
- IDLE:
  - ip_clear -> ip=IP_RESET.
  - en=1 -> FETCH next cycle.
  - If both are asserted, the clear is applied and the FSM moves to FETCH.
- FETCH:
  - fetch_req=1, combinational from state.
  - Stay until fetch_ack; on fetch_ack -> EXEC.
  - en is ignored in this state.
- EXEC: exactly one cycle; the execution-stage inputs are sampled in this cycle. Priority order:
  - Zero-size check: ip_incr==0 and ip_load==0 -> error=1, HALT. No commit, ip unchanged.
  - hm_start=1 -> hm_req=1 this cycle, HM_WAIT. No commit; ip unchanged.
  - user_irq=1 -> irq=1 from next cycle, ip updated, instr_count+1, IRQ_WAIT. exec_commit=0.
  - Otherwise -> exec_commit=1 this cycle, ip updated, instr_count+1. Next state is FETCH if en=1, else IDLE.
- HM_WAIT:
  - Hold until hm_ack; the decoded instruction must stay stable meanwhile.
  - On hm_ack: exec_commit=1 in the same cycle, ip updated, instr_count+1. Next state is FETCH if en=1, else IDLE.
  - hm_req is not re-asserted while waiting.
- IRQ_WAIT:
  - irq held at 1.
  - On irq_clear: irq=0 next cycle. Next state is FETCH if en=1, else IDLE.
- HALT:
  - Holds until ip_clear, which sets ip=IP_RESET, clears error and goes to IDLE.
  - en is ignored.
- IP update: ip <= ip_load ? ip_data : ip + ip_incr, modulo 2^16 (wraps; no carry out).
- instr_count wraps modulo 2^32.
- Stray inputs:
  - hm_ack outside HM_WAIT is ignored.
  - irq_clear outside IRQ_WAIT is ignored.
  - fetch_ack outside FETCH is ignored.
- en deassert mid-instruction: the current instruction completes, then IDLE. Never abort between request and response.
- running=1 in FETCH, EXEC, HM_WAIT and IRQ_WAIT.
- fetch_req, hm_req and exec_commit are combinational from state and inputs. All other outputs are registered.

Test Plan:
- Reset then en=1, fetch_ack in 2nd FETCH cycle, ip_incr=4, no load -> fetch_req high 2 cycles; one exec_commit pulse; ip 0->4; instr_count=1; loops back to FETCH.
- Jump: EXEC with ip_load=1, ip_data=16'h0040 -> ip=16'h0040, exec_commit=1, next fetch at 0x0040.
- Host load: EXEC with hm_start=1 -> single hm_req pulse, exec_commit=0. hm_ack 5 cycles later -> exec_commit=1 that cycle, ip+=isize. An hm_ack injected before the request is ignored.
- Interrupt: EXEC with user_irq=1, ip=8, ip_incr=2 -> irq=1 next cycle, ip=10, no commit. Held 10 cycles until irq_clear -> irq=0, FETCH at ip=10.
- Wrap and zero size:
  - ip=16'hFFFE, ip_incr=4 -> ip=16'h0002.
  - Then ip_incr=0, ip_load=0 -> error=1, HALT, running=0.
  - ip_clear -> ip=0, error=0, IDLE.
- en dropped during HM_WAIT -> on hm_ack the commit still occurs, then IDLE. sys_rst asserted in IRQ_WAIT -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/mpu_sequencer_if.sv
`default_nettype none
// ============================================================================
// mpu_sequencer_if : handshake bundle between the MPU sequencer and the
//                    CSR/host, instruction memory and execution stage.
// Rev 1.0
// ============================================================================
interface mpu_sequencer_if;
  logic        en;
  logic        ip_clear;
  logic [15:0] ip;
  logic        fetch_req;
  logic        fetch_ack;
  logic        exec_commit;
  logic [15:0] ip_incr;
  logic        ip_load;
  logic [15:0] ip_data;
  logic        hm_start;
  logic        hm_req;
  logic        hm_ack;
  logic        user_irq;
  logic        irq;
  logic        irq_clear;
  logic        running;
  logic        error;
  logic [31:0] instr_count;

  modport master (
    input  en, ip_clear, fetch_ack, ip_incr, ip_load, ip_data,
           hm_start, hm_ack, user_irq, irq_clear,
    output ip, fetch_req, exec_commit, hm_req, irq, running, error, instr_count
  );

  modport slave (
    output en, ip_clear, fetch_ack, ip_incr, ip_load, ip_data,
           hm_start, hm_ack, user_irq, irq_clear,
    input  ip, fetch_req, exec_commit, hm_req, irq, running, error, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/mpu_sequencer.sv
`default_nettype none
// ============================================================================
// mpu_sequencer : control FSM owning the instruction pointer, fetch requests,
//                 execute window, host-memory and interrupt stalls.
// Rev 1.0
// ============================================================================
module mpu_sequencer #(
  parameter logic [15:0] IP_RESET = 16'h0000
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  mpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_HM_WAIT  = 3'd3,
    S_IRQ_WAIT = 3'd4,
    S_HALT     = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_ip;
  logic        r_irq;
  logic        r_running;
  logic        r_error;
  logic [31:0] r_instr_count;

  logic        w_in_exec;
  logic        w_zero_size;
  logic        w_hm_issue;
  logic        w_exec_plain;
  logic        w_hm_done;
  logic [15:0] w_ip_next;

  // A taken jump with zero size is legal; only a non-advancing fall-through is fatal.
  assign w_in_exec    = (r_state == S_EXEC);
  assign w_zero_size  = (bus.ip_incr == 16'd0) && !bus.ip_load;
  assign w_hm_issue   = w_in_exec && !w_zero_size && bus.hm_start;
  assign w_exec_plain = w_in_exec && !w_zero_size && !bus.hm_start && !bus.user_irq;
  assign w_hm_done    = (r_state == S_HM_WAIT) && bus.hm_ack;
  assign w_ip_next    = bus.ip_load ? bus.ip_data : (r_ip + bus.ip_incr);

  assign bus.fetch_req   = (r_state == S_FETCH);
  assign bus.hm_req      = w_hm_issue;
  assign bus.exec_commit = w_exec_plain || w_hm_done;
  assign bus.ip          = r_ip;
  assign bus.irq         = r_irq;
  assign bus.running     = r_running;
  assign bus.error       = r_error;
  assign bus.instr_count = r_instr_count;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= S_IDLE;
      r_ip          <= IP_RESET;
      r_irq         <= 1'b0;
      r_running     <= 1'b0;
      r_error       <= 1'b0;
      r_instr_count <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.ip_clear) begin
            r_ip <= IP_RESET;
          end
          if (bus.en) begin
            r_state   <= S_FETCH;
            r_running <= 1'b1;
          end
        end

        S_FETCH: begin
          if (bus.fetch_ack) begin
            r_state <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (w_zero_size) begin
            r_error   <= 1'b1;
            r_state   <= S_HALT;
            r_running <= 1'b0;
          end else if (bus.hm_start) begin
            r_state <= S_HM_WAIT;
          end else if (bus.user_irq) begin
            r_irq         <= 1'b1;
            r_ip          <= w_ip_next;
            r_instr_count <= r_instr_count + 32'd1;
            r_state       <= S_IRQ_WAIT;
          end else begin
            r_ip          <= w_ip_next;
            r_instr_count <= r_instr_count + 32'd1;
            r_state       <= bus.en ? S_FETCH : S_IDLE;
            r_running     <= bus.en;
          end
        end

        // Decoder outputs are held stable by the host, so w_ip_next is still valid here.
        S_HM_WAIT: begin
          if (bus.hm_ack) begin
            r_ip          <= w_ip_next;
            r_instr_count <= r_instr_count + 32'd1;
            r_state       <= bus.en ? S_FETCH : S_IDLE;
            r_running     <= bus.en;
          end
        end

        S_IRQ_WAIT: begin
          if (bus.irq_clear) begin
            r_irq     <= 1'b0;
            r_state   <= bus.en ? S_FETCH : S_IDLE;
            r_running <= bus.en;
          end
        end

        S_HALT: begin
          if (bus.ip_clear) begin
            r_ip    <= IP_RESET;
            r_error <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mpu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mpu_sequencer : directed scoreboard bench for mpu_sequencer.
// Rev 1.0
// ============================================================================
module tb_mpu_sequencer;

  logic sys_clk = 1'b0;
  logic sys_rst;

  always #5 sys_clk = ~sys_clk;

  mpu_sequencer_if bus ();

  mpu_sequencer #(.IP_RESET(16'h0000)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [15:0] ip;
    logic [31:0] cnt;
  } commit_t;

  commit_t     sb_q[$];
  commit_t     mon_exp;
  bit          mon_pending = 1'b0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] m_ip;
  logic [31:0] m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Each commit pulse is matched against the oldest expectation one cycle later,
  // once the registered ip/instr_count have updated.
  always @(negedge sys_clk) begin
    if (mon_pending) begin
      mon_pending = 1'b0;
      if (sb_q.size() == 0) begin
        check("commit_unexpected", 32'd1, 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("commit_ip", {16'd0, bus.ip}, {16'd0, mon_exp.ip});
        check("commit_cnt", bus.instr_count, mon_exp.cnt);
      end
    end
    if (!sys_rst && bus.exec_commit) mon_pending = 1'b1;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_exec(input logic [15:0] incr, input logic ld, input logic [15:0] data,
                          input logic hm, input logic uirq);
    bus.ip_incr  = incr;
    bus.ip_load  = ld;
    bus.ip_data  = data;
    bus.hm_start = hm;
    bus.user_irq = uirq;
  endtask

  // Entered in FETCH; leaves in EXEC.
  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) begin
      @(negedge sys_clk);
      check("fetch_req_wait", {31'd0, bus.fetch_req}, 32'd1);
      tick();
    end
    bus.fetch_ack = 1'b1;
    @(negedge sys_clk);
    check("fetch_req_ack", {31'd0, bus.fetch_req}, 32'd1);
    check("fetch_ip", {16'd0, bus.ip}, {16'd0, m_ip});
    tick();
    bus.fetch_ack = 1'b0;
  endtask

  task automatic exec_plain(input logic [15:0] incr, input logic ld, input logic [15:0] data);
    set_exec(incr, ld, data, 1'b0, 1'b0);
    m_ip  = ld ? data : m_ip + incr;
    m_cnt = m_cnt + 32'd1;
    sb_q.push_back('{ip: m_ip, cnt: m_cnt});
    @(negedge sys_clk);
    check("exec_hm_req", {31'd0, bus.hm_req}, 32'd0);
    tick();
  endtask

  task automatic host_load(input logic [15:0] incr, input int waits, input bit drop_en);
    set_exec(incr, 1'b0, 16'd0, 1'b1, 1'b0);
    @(negedge sys_clk);
    check("hm_req_issue", {31'd0, bus.hm_req}, 32'd1);
    check("hm_issue_commit", {31'd0, bus.exec_commit}, 32'd0);
    tick();
    if (drop_en) bus.en = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge sys_clk);
      check("hm_wait_req", {31'd0, bus.hm_req}, 32'd0);
      check("hm_wait_commit", {31'd0, bus.exec_commit}, 32'd0);
      check("hm_wait_ip", {16'd0, bus.ip}, {16'd0, m_ip});
      tick();
    end
    bus.hm_ack = 1'b1;
    m_ip  = m_ip + incr;
    m_cnt = m_cnt + 32'd1;
    sb_q.push_back('{ip: m_ip, cnt: m_cnt});
    tick();
    bus.hm_ack   = 1'b0;
    bus.hm_start = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ip"}, {16'd0, bus.ip}, 32'd0);
    check({tag, "_fetch_req"}, {31'd0, bus.fetch_req}, 32'd0);
    check({tag, "_commit"}, {31'd0, bus.exec_commit}, 32'd0);
    check({tag, "_hm_req"}, {31'd0, bus.hm_req}, 32'd0);
    check({tag, "_irq"}, {31'd0, bus.irq}, 32'd0);
    check({tag, "_running"}, {31'd0, bus.running}, 32'd0);
    check({tag, "_error"}, {31'd0, bus.error}, 32'd0);
    check({tag, "_count"}, bus.instr_count, 32'd0);
  endtask

  initial begin
    sys_rst       = 1'b1;
    bus.en        = 1'b0;
    bus.ip_clear  = 1'b0;
    bus.fetch_ack = 1'b0;
    bus.hm_ack    = 1'b0;
    bus.irq_clear = 1'b0;
    set_exec(16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    m_ip  = 16'h0000;
    m_cnt = 32'd0;
    tick();
    tick();
    @(negedge sys_clk);
    check_reset_state("rst");
    sys_rst = 1'b0;
    tick();

    // Basic sequential instructions, ack in second FETCH cycle
    bus.en = 1'b1;
    tick();
    fetch(1);
    exec_plain(16'd4, 1'b0, 16'd0);
    fetch(0);
    exec_plain(16'd4, 1'b0, 16'd0);

    // Interrupt at ip=8, size 2
    fetch(0);
    set_exec(16'd2, 1'b0, 16'd0, 1'b0, 1'b1);
    @(negedge sys_clk);
    check("irq_exec_commit", {31'd0, bus.exec_commit}, 32'd0);
    check("irq_exec_hm_req", {31'd0, bus.hm_req}, 32'd0);
    m_ip  = m_ip + 16'd2;
    m_cnt = m_cnt + 32'd1;
    tick();
    bus.user_irq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.hm_ack = (i == 3);
      @(negedge sys_clk);
      check("irq_held", {31'd0, bus.irq}, 32'd1);
      tick();
    end
    bus.hm_ack = 1'b0;
    check("irq_ip", {16'd0, bus.ip}, {16'd0, m_ip});
    check("irq_count", bus.instr_count, m_cnt);
    bus.irq_clear = 1'b1;
    tick();
    bus.irq_clear = 1'b0;
    @(negedge sys_clk);
    check("irq_cleared", {31'd0, bus.irq}, 32'd0);
    tick();
    fetch(0);

    // Jump to 0x0040, then host load with a stray early hm_ack
    exec_plain(16'd0, 1'b1, 16'h0040);
    bus.hm_ack = 1'b1;
    fetch(1);
    bus.hm_ack = 1'b0;
    host_load(16'd2, 4, 1'b0);

    // Wrap, zero size, halt and clear
    fetch(0);
    exec_plain(16'd0, 1'b1, 16'hFFFE);
    fetch(0);
    exec_plain(16'd4, 1'b0, 16'd0);
    fetch(0);
    set_exec(16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("zero_commit", {31'd0, bus.exec_commit}, 32'd0);
    tick();
    @(negedge sys_clk);
    check("halt_error", {31'd0, bus.error}, 32'd1);
    check("halt_running", {31'd0, bus.running}, 32'd0);
    check("halt_ip", {16'd0, bus.ip}, 32'h0002);
    tick();
    @(negedge sys_clk);
    check("halt_hold_fetch", {31'd0, bus.fetch_req}, 32'd0);
    bus.ip_clear = 1'b1;
    tick();
    bus.ip_clear = 1'b0;
    m_ip = 16'h0000;
    @(negedge sys_clk);
    check("clear_ip", {16'd0, bus.ip}, 32'd0);
    check("clear_error", {31'd0, bus.error}, 32'd0);
    check("clear_running", {31'd0, bus.running}, 32'd0);
    tick();

    // en dropped while waiting on host memory
    set_exec(16'd6, 1'b0, 16'd0, 1'b0, 1'b0);
    fetch(0);
    host_load(16'd6, 2, 1'b1);
    @(negedge sys_clk);
    check("en_drop_idle_running", {31'd0, bus.running}, 32'd0);
    check("en_drop_idle_fetch", {31'd0, bus.fetch_req}, 32'd0);
    bus.ip_clear = 1'b1;
    bus.en       = 1'b1;
    tick();
    bus.ip_clear = 1'b0;
    m_ip = 16'h0000;
    fetch(0);

    // Reset while in IRQ_WAIT
    set_exec(16'd2, 1'b0, 16'd0, 1'b0, 1'b1);
    tick();
    set_exec(16'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    @(negedge sys_clk);
    check("irqwait_irq", {31'd0, bus.irq}, 32'd1);
    sys_rst = 1'b1;
    tick();
    @(negedge sys_clk);
    check_reset_state("rst_irq");
    sys_rst = 1'b0;
    bus.en  = 1'b0;
    tick();
    tick();
    check("sb_drained", sb_q.size(), 32'd0);
    check("sb_no_pending", {31'd0, mon_pending}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
